mio_cli_st_xfer_chkr: RTL
=========================

# mio_cli_st_xfer_chkr

Parametrised, synthesizable transfer checker for the MIO CLI self-test environment. It watches the bob (sender) and alice (receiver) valid/ready streams and keeps a per-channel expected-data FIFO of bob beats. Each alice beat is compared in order against its channel's FIFO head, and mismatches, unexpected beats, overflows, illegal channels and stalls are reported as sticky error flags with counters. It sits in the self-test harness next to the two agent interfaces and replaces assertion-only checking with cycle-accurate scoreboarding.

## Interface
- DATA_W, 32, beat data width (>=1)
- NUM_CH, 4, number of logical channels (1..16); CH_W = max(1, clog2(NUM_CH))
- DEPTH, 8, per-channel FIFO entries, power of 2, >=2
- TIMEOUT, 1024, max cycles a FIFO head may wait; 0 disables timeout checking
- CNT_W, 16, width of match counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  checking enabled; when 0, beats are ignored and timeout counters hold
- clear  in  1  synchronous clear of FIFOs, counters, errors
- bob_valid, bob_ready  in  1 each  sender handshake
- bob_ch  in  CH_W  sender channel id
- bob_data  in  DATA_W  sender data
- alice_valid, alice_ready  in  1 each  receiver handshake
- alice_ch  in  CH_W  receiver channel id
- alice_data  in  DATA_W  receiver data
- err  out  5  sticky flags: [0] mismatch, [1] unexpected, [2] overflow, [3] timeout, [4] illegal channel
- err_ch  out  CH_W  channel of the first error captured
- match_cnt  out  CNT_W  matched beats, saturating at all-ones
- pending  out  clog2(NUM_CH*DEPTH+1)  total entries held across all FIFOs
- idle  out  1  all FIFOs empty

## Operation
- Beat = valid & ready sampled at a rising clk edge with enable=1 and clear=0.
- Bob beat, ch < NUM_CH: push data onto FIFO[ch]. If FIFO[ch] is full and there is no same-edge alice pop on ch: drop the data and set err[2].
- Bob beat, ch >= NUM_CH: drop it and set err[4].
- Alice beat, ch >= NUM_CH: set err[4].
- Alice beat, FIFO[ch] empty: set err[1]. A bob push on the same channel in the same cycle is not visible to this alice beat.
- Alice beat, FIFO[ch] non-empty: pop the head. Data equal -> increment match_cnt (saturating). Data different -> set err[0].
- Full FIFO with simultaneous push and pop on the same channel: both take effect, occupancy unchanged, no overflow.
- Timeout, per channel, when TIMEOUT>0:
  - tcnt[ch] increments each enabled cycle while FIFO[ch] is non-empty.
  - tcnt[ch] resets to 0 on a pop or when the FIFO becomes empty.
  - When tcnt reaches TIMEOUT, set err[3]; tcnt then saturates at TIMEOUT. The entry is not discarded.
- Error flags are sticky until reset or clear.
- err_ch is loaded only on the edge where err goes from all-zero to non-zero.
  - Source priority on that edge: lowest err bit index first, then alice before bob, then lowest channel for timeout.
  - For err[4], err_ch takes the offending id truncated to CH_W.
- clear=1: all FIFOs are emptied, tcnt, match_cnt, err and err_ch go to 0, and beats in that cycle are ignored. clear wins over simultaneous beats.
- pending and idle are combinational from the registered FIFO occupancies.

## Timing
- Reset values: err=0, err_ch=0, match_cnt=0, pending=0, idle=1. All FIFOs are empty and tcnt=0.
- Reset asserted mid-operation takes effect immediately and discards all state. The first beat is sampled at the first edge after reset deasserts.
- err, err_ch and match_cnt are registered. They update on the edge that samples the triggering beat and are visible in the following cycle (1-cycle latency).
- pending and idle reflect a push or pop in the cycle after the sampling edge.
- FIFO pointers carry an extra wrap bit: full = pointers equal except the MSB. Wrap-around is seamless over repeated fill/drain.
- No combinational path from any input to any output other than through registers.

## Test plan
- In-order match: NUM_CH=4, bob sends ch2 data 0xA5,0x5A,0x33, then alice returns the same -> match_cnt=3, err=0, idle=1.
- Mismatch and unexpected: bob sends ch0 0x11, alice returns ch0 0x12 -> err[0]=1, err_ch=0. Then alice sends ch1 with FIFO empty -> err[1]=1, err_ch stays 0.
- Full boundary: DEPTH=8, 8 bob beats on ch3, then a 9th -> err[2]=1, pending=8. Repeat with a simultaneous alice pop on ch3 for the 9th -> no err[2], pending=8.
- Timeout: TIMEOUT=16, single bob beat on ch1 at edge 0, no alice -> err[3] first visible after edge 16, err_ch=1. Same test with TIMEOUT=0 -> err stays 0.
- Illegal channel plus clear: NUM_CH=3, bob_ch=3 -> err[4]=1, err_ch=3. Pulse clear with a concurrent bob beat -> err=0, pending=0, and the beat is ignored.
- Reset mid-flight: 5 entries pending on mixed channels, assert reset asynchronously between edges -> outputs go to reset values immediately, and a subsequent alice beat raises err[1].

Source files
------------

// File: rtl/mio_cli_st_xfer_chkr.sv
// Per-channel in-order scoreboard between the bob (sender) and alice (receiver) streams.
// Bob beats fill per-channel expected-data FIFOs; alice beats pop and compare, raising sticky errors.
module mio_cli_st_xfer_chkr #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PEND_W  = $clog2(NUM_CH * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              bob_valid,
  input  logic              bob_ready,
  input  logic [CH_W-1:0]   bob_ch,
  input  logic [DATA_W-1:0] bob_data,
  input  logic              alice_valid,
  input  logic              alice_ready,
  input  logic [CH_W-1:0]   alice_ch,
  input  logic [DATA_W-1:0] alice_data,
  output logic [4:0]        err,
  output logic [CH_W-1:0]   err_ch,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [PEND_W-1:0] pending,
  output logic              idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [AW:0]       wr_ptr [NUM_CH];
  logic [AW:0]       rd_ptr [NUM_CH];
  logic [AW:0]       occ [NUM_CH];
  logic [TW-1:0]     tcnt [NUM_CH];
  logic [TW-1:0]     tcnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] empty, full, tmo;

  logic              b_beat, a_beat, b_legal, a_legal;
  logic [CH_W-1:0]   b_idx, a_idx, src_ch;
  logic [DATA_W-1:0] head;
  logic              a_pop, a_unexp, a_mism, a_match, b_push, b_ovf, same_pop;
  logic              tmo_found;
  logic [4:0]        new_err;

  // Occupancy derives from pointers carrying an extra wrap bit.
  always_comb begin
    pending = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      occ[c]   = wr_ptr[c] - rd_ptr[c];
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c] == {~rd_ptr[c][AW], rd_ptr[c][AW-1:0]});
      pending  = pending + PEND_W'(occ[c]);
    end
    idle = &empty;
  end

  always_comb begin
    b_beat   = enable & ~clear & bob_valid & bob_ready;
    a_beat   = enable & ~clear & alice_valid & alice_ready;
    b_legal  = 32'(bob_ch) < NUM_CH;
    a_legal  = 32'(alice_ch) < NUM_CH;
    b_idx    = b_legal ? bob_ch : '0;
    a_idx    = a_legal ? alice_ch : '0;
    head     = mem[a_idx][rd_ptr[a_idx][AW-1:0]];
    a_pop    = a_beat & a_legal & ~empty[a_idx];
    a_unexp  = a_beat & a_legal & empty[a_idx];
    a_mism   = a_pop & (head != alice_data);
    a_match  = a_pop & (head == alice_data);
    // A same-edge pop on a full channel frees the slot the push needs.
    same_pop = a_pop & (alice_ch == bob_ch);
    b_push   = b_beat & b_legal & (~full[b_idx] | same_pop);
    b_ovf    = b_beat & b_legal & full[b_idx] & ~same_pop;

    tmo = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      tcnt_nxt[c] = tcnt[c];
      if (TIMEOUT == 0) begin
        tcnt_nxt[c] = '0;
      end else if (enable) begin
        if (empty[c] || (a_pop && a_idx == CH_W'(c))) begin
          tcnt_nxt[c] = '0;
        end else if (tcnt[c] != TW'(TIMEOUT)) begin
          tcnt_nxt[c] = tcnt[c] + TW'(1);
          tmo[c]      = (tcnt[c] == TW'(TIMEOUT - 1));
        end
      end
    end

    new_err = {(a_beat & ~a_legal) | (b_beat & ~b_legal), |tmo, b_ovf, a_unexp, a_mism};

    src_ch    = '0;
    tmo_found = 1'b0;
    if (a_mism || a_unexp) begin
      src_ch = alice_ch;
    end else if (b_ovf) begin
      src_ch = bob_ch;
    end else if (|tmo) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (tmo[c] && !tmo_found) begin
          src_ch    = CH_W'(c);
          tmo_found = 1'b1;
        end
      end
    end else if (a_beat && !a_legal) begin
      src_ch = alice_ch;
    end else begin
      src_ch = bob_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (b_push) mem[b_idx][wr_ptr[b_idx][AW-1:0]] <= bob_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        tcnt[c]   <= '0;
      end
      err       <= '0;
      err_ch    <= '0;
      match_cnt <= '0;
    end else if (clear) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        tcnt[c]   <= '0;
      end
      err       <= '0;
      err_ch    <= '0;
      match_cnt <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (b_push && b_idx == CH_W'(c)) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
        if (a_pop && a_idx == CH_W'(c))  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
        tcnt[c] <= tcnt_nxt[c];
      end
      err <= err | new_err;
      if (err == '0 && new_err != '0) err_ch <= src_ch;
      if (a_match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
